// File: rtl/alu_pkg.sv
// Shared ALU sequencing types: opcode and sequencer state encodings, field widths
// and a small opcode classifier used by the datapath blocks.
package alu_pkg;

  localparam int OP_W   = 3;
  localparam int FLAG_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_MOD  = 3'd4,
    OP_MOV  = 3'd5,
    OP_ILL6 = 3'd6,
    OP_ILL7 = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

  function automatic logic is_divmod(input alu_op_t op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_result_mux.sv
// Combinational select of one ALU result/flag pair by opcode; opcodes outside
// the defined set return zero and raise illegal.
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  alu_op_t           op,
  input  logic [N-1:0]      alu_rs,
  input  logic [N-1:0]      alu_rr,
  input  logic [N-1:0]      alu_rm,
  input  logic [N-1:0]      alu_rd,
  input  logic [N-1:0]      alu_rmod,
  input  logic [N-1:0]      alu_rmov,
  input  logic [FLAG_W-1:0] alu_fs,
  input  logic [FLAG_W-1:0] alu_fr,
  input  logic [FLAG_W-1:0] alu_fm,
  input  logic [FLAG_W-1:0] alu_fd,
  input  logic [FLAG_W-1:0] alu_fmod,
  input  logic [FLAG_W-1:0] alu_fmov,
  output logic [N-1:0]      result,
  output logic [FLAG_W-1:0] flags,
  output logic              illegal
);

  // result/flag selection by opcode
  always_comb begin
    result  = {N{1'b0}};
    flags   = {FLAG_W{1'b0}};
    illegal = 1'b0;
    case (op)
      OP_ADD:  begin result = alu_rs;   flags = alu_fs;   end
      OP_SUB:  begin result = alu_rr;   flags = alu_fr;   end
      OP_MUL:  begin result = alu_rm;   flags = alu_fm;   end
      OP_DIV:  begin result = alu_rd;   flags = alu_fd;   end
      OP_MOD:  begin result = alu_rmod; flags = alu_fmod; end
      OP_MOV:  begin result = alu_rmov; flags = alu_fmov; end
      default: begin
        result  = {N{1'b0}};
        flags   = {FLAG_W{1'b0}};
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time through the shared combinational ALU.
// Optional: define ALU_OP_SEQUENCER_DIVZ_EN to short-circuit DIV/MOD by zero with rsp_err.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N        = 32,
  parameter int MUL_WAIT = 1,
  parameter int DIV_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [N-1:0]      req_a,
  input  logic [N-1:0]      req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  input  logic [N-1:0]      alu_rs,
  input  logic [N-1:0]      alu_rr,
  input  logic [N-1:0]      alu_rm,
  input  logic [N-1:0]      alu_rd,
  input  logic [N-1:0]      alu_rmod,
  input  logic [N-1:0]      alu_rmov,
  input  logic [FLAG_W-1:0] alu_fs,
  input  logic [FLAG_W-1:0] alu_fr,
  input  logic [FLAG_W-1:0] alu_fm,
  input  logic [FLAG_W-1:0] alu_fd,
  input  logic [FLAG_W-1:0] alu_fmod,
  input  logic [FLAG_W-1:0] alu_fmov
);

  seq_state_t        state_r;
  alu_op_t           op_r;
  logic [3:0]        cnt_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic [N-1:0]      rsp_result_r;
  logic [FLAG_W-1:0] rsp_flags_r;
  logic [N-1:0]      alu_a_r;
  logic [N-1:0]      alu_b_r;

  logic [N-1:0]      mux_result_s;
  logic [FLAG_W-1:0] mux_flags_s;
  logic              mux_illegal_s;
  logic              divz_s;
  logic [N-1:0]      cap_result_s;
  logic [FLAG_W-1:0] cap_flags_s;
  logic              cap_err_s;
  logic [3:0]        load_cnt_s;

  alu_result_mux #(.N(N)) u_mux (
    .op       (op_r),
    .alu_rs   (alu_rs),
    .alu_rr   (alu_rr),
    .alu_rm   (alu_rm),
    .alu_rd   (alu_rd),
    .alu_rmod (alu_rmod),
    .alu_rmov (alu_rmov),
    .alu_fs   (alu_fs),
    .alu_fr   (alu_fr),
    .alu_fm   (alu_fm),
    .alu_fd   (alu_fd),
    .alu_fmod (alu_fmod),
    .alu_fmov (alu_fmov),
    .result   (mux_result_s),
    .flags    (mux_flags_s),
    .illegal  (mux_illegal_s)
  );

  // settle budget for the incoming opcode
  always_comb begin
    load_cnt_s = 4'd0;
    case (alu_op_t'(req_op))
      OP_MUL:         load_cnt_s = 4'(MUL_WAIT);
      OP_DIV, OP_MOD: load_cnt_s = 4'(DIV_WAIT);
      default:        load_cnt_s = 4'd0;
    endcase
  end

  // divide-by-zero detection on the held divisor
  always_comb begin
    divz_s = 1'b0;
`ifdef ALU_OP_SEQUENCER_DIVZ_EN
    if (is_divmod(op_r) && (alu_b_r == {N{1'b0}})) begin
      divz_s = 1'b1;
    end else begin
      divz_s = 1'b0;
    end
`else
    divz_s = 1'b0;
`endif
  end

  // value captured into the response registers
  always_comb begin
    cap_result_s = mux_result_s;
    cap_flags_s  = mux_flags_s;
    cap_err_s    = mux_illegal_s;
    if (divz_s) begin
      cap_result_s = {N{1'b0}};
      cap_flags_s  = {FLAG_W{1'b0}};
      cap_err_s    = 1'b1;
    end else begin
      cap_result_s = mux_result_s;
      cap_flags_s  = mux_flags_s;
      cap_err_s    = mux_illegal_s;
    end
  end

  // sequencer FSM, operand holding and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      op_r         <= OP_ADD;
      cnt_r        <= 4'd0;
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
      rsp_result_r <= {N{1'b0}};
      rsp_flags_r  <= {FLAG_W{1'b0}};
      alu_a_r      <= {N{1'b0}};
      alu_b_r      <= {N{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid && req_ready_r) begin
            alu_a_r     <= req_a;
            alu_b_r     <= req_b;
            op_r        <= alu_op_t'(req_op);
            cnt_r       <= load_cnt_s;
            req_ready_r <= 1'b0;
            state_r     <= S_EXEC;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (divz_s || (cnt_r == 4'd0)) begin
            rsp_result_r <= cap_result_s;
            rsp_flags_r  <= cap_flags_s;
            rsp_err_r    <= cap_err_s;
            rsp_valid_r  <= 1'b1;
            state_r      <= S_DONE;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            rsp_result_r <= cap_result_s;
            rsp_flags_r  <= cap_flags_s;
            rsp_err_r    <= cap_err_s;
            rsp_valid_r  <= 1'b1;
            state_r      <= S_DONE;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_DONE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_flags  = rsp_flags_r;
  assign rsp_err    = rsp_err_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, transaction-level
// reference model checked every cycle, and directed vectors with literal expectations.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_rs, alu_rr, alu_rm, alu_rd, alu_rmod, alu_rmov;
  logic [3:0]  alu_fs, alu_fr, alu_fm, alu_fd, alu_fmod, alu_fmov;

  int checks = 0;
  int errors = 0;
  logic started = 1'b0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_rs(alu_rs), .alu_rr(alu_rr), .alu_rm(alu_rm), .alu_rd(alu_rd),
    .alu_rmod(alu_rmod), .alu_rmov(alu_rmov),
    .alu_fs(alu_fs), .alu_fr(alu_fr), .alu_fm(alu_fm), .alu_fd(alu_fd),
    .alu_fmod(alu_fmod), .alu_fmov(alu_fmov)
  );

  // flag nibble: source id + 1, with bit 0 toggled on a zero result
  function automatic logic [3:0] flag_of(input int src, input logic [31:0] r);
    return 4'(src + 1) ^ {3'b000, (r == 32'd0)};
  endfunction

  function automatic logic [31:0] do_div(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic logic [31:0] do_mod(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? a : a % b;
  endfunction

  // environment ALU
  assign alu_rs   = alu_a + alu_b;
  assign alu_rr   = alu_a - alu_b;
  assign alu_rm   = alu_a * alu_b;
  assign alu_rd   = do_div(alu_a, alu_b);
  assign alu_rmod = do_mod(alu_a, alu_b);
  assign alu_rmov = alu_b;
  assign alu_fs   = flag_of(0, alu_rs);
  assign alu_fr   = flag_of(1, alu_rr);
  assign alu_fm   = flag_of(2, alu_rm);
  assign alu_fd   = flag_of(3, alu_rd);
  assign alu_fmod = flag_of(4, alu_rmod);
  assign alu_fmov = flag_of(5, alu_rmov);

  function automatic logic divz_hit(input logic [2:0] op, input logic [31:0] b);
`ifdef ALU_OP_SEQUENCER_DIVZ_EN
    return ((op == 3'd3) || (op == 3'd4)) && (b == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] b);
    if (divz_hit(op, b)) return 2;
    case (op)
      3'd2:       return 2 + 1;
      3'd3, 3'd4: return 2 + 4;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    if (divz_hit(op, b)) return 32'd0;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return do_div(a, b);
      3'd4:    return do_mod(a, b);
      3'd5:    return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] model_flags(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    if (divz_hit(op, b) || (op > 3'd5)) return 4'd0;
    return flag_of(int'(op), model_res(op, a, b));
  endfunction

  // transaction model: busy for a latency countdown, then holds the result until taken
  logic        m_busy, m_valid, m_err, p_err;
  int          m_left;
  logic [31:0] m_a, m_b, m_result, p_result;
  logic [3:0]  m_flags, p_flags;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_left <= 0;
      m_a <= 32'd0; m_b <= 32'd0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy   <= 1'b1;
        m_left   <= model_lat(req_op, req_b) - 1;
        m_a      <= req_a;
        m_b      <= req_b;
        p_result <= model_res(req_op, req_a, req_b);
        p_flags  <= model_flags(req_op, req_a, req_b);
        p_err    <= (req_op > 3'd5) || divz_hit(req_op, req_b);
      end
    end else if (m_valid) begin
      if (rsp_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid  <= 1'b1;
        m_result <= p_result;
        m_flags  <= p_flags;
        m_err    <= p_err;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("cmp_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("cmp_req_ready", 32'(req_ready), 32'(!m_busy));
      check("cmp_alu_a", alu_a, m_a);
      check("cmp_alu_b", alu_b, m_b);
      if (m_valid) begin
        check("cmp_result", rsp_result, m_result);
        check("cmp_flags", 32'(rsp_flags), 32'(m_flags));
        check("cmp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int exp_lat, input logic [31:0] exp_res,
                        input logic [3:0] exp_flags, input logic exp_err);
    int lat;
    @(negedge clk);
    check("pre_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    rsp_ready = (hold == 0);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 40);
    check("latency", 32'(lat), 32'(exp_lat));
    check("lit_result", rsp_result, exp_res);
    check("lit_flags", 32'(rsp_flags), 32'(exp_flags));
    check("lit_err", 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd0; req_a = 32'd1; req_b = 32'd1;
      check("hold_result", rsp_result, exp_res);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    started = 1'b1;
    rst = 1'b0;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_result", rsp_result, 32'd0);
    check("rst_flags", 32'(rsp_flags), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);

    run_op(3'd0, 32'd5, 32'd7, 0, 2, 32'd12, 4'd1, 1'b0);
    run_op(3'd1, 32'd5, 32'd7, 0, 2, 32'hFFFF_FFFE, 4'd2, 1'b0);
    run_op(3'd2, 32'd6, 32'd7, 0, 3, 32'd42, 4'd3, 1'b0);
    run_op(3'd3, 32'd100, 32'd7, 0, 6, 32'd14, 4'd4, 1'b0);
    run_op(3'd4, 32'd100, 32'd7, 5, 6, 32'd2, 4'd5, 1'b0);
    run_op(3'd5, 32'd9, 32'h1234, 0, 2, 32'h1234, 4'd6, 1'b0);
    run_op(3'd7, 32'd3, 32'd4, 0, 2, 32'd0, 4'd0, 1'b1);
    run_op(3'd6, 32'd3, 32'd4, 1, 2, 32'd0, 4'd0, 1'b1);
    run_op(3'd0, 32'hFFFF_FFFF, 32'd1, 0, 2, 32'd0, 4'd0, 1'b0);
`ifdef ALU_OP_SEQUENCER_DIVZ_EN
    run_op(3'd3, 32'd9, 32'd0, 0, 2, 32'd0, 4'd0, 1'b1);
    run_op(3'd4, 32'd9, 32'd0, 0, 2, 32'd0, 4'd0, 1'b1);
`else
    run_op(3'd3, 32'd9, 32'd0, 0, 6, 32'hFFFF_FFFF, 4'd4, 1'b0);
    run_op(3'd4, 32'd9, 32'd0, 0, 6, 32'd9, 4'd5, 1'b0);
`endif

    // reset while a DIV is waiting
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; req_a = 32'd100; req_b = 32'd7; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_alu_a", alu_a, 32'd0);
    check("midrst_alu_b", alu_b, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;

    run_op(3'd2, 32'd3, 32'd5, 2, 3, 32'd15, 4'd3, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
